// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: funct encodings and FSM states.
package alu_pkg;

    localparam logic [5:0] F_ADDU  = 6'b001001;
    localparam logic [5:0] F_SUBU  = 6'b001010;
    localparam logic [5:0] F_AND   = 6'b010001;
    localparam logic [5:0] F_OR    = 6'b010010;
    localparam logic [5:0] F_XOR   = 6'b010011;
    localparam logic [5:0] F_SLL   = 6'b100001;
    localparam logic [5:0] F_SRL   = 6'b100010;
    localparam logic [5:0] F_SRA   = 6'b100011;
    localparam logic [5:0] F_SLTU  = 6'b101011;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010100;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register-read stage, the ALU and writeback.
interface alu_seq_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   src_data;
    logic [WIDTH-1:0]   tar_data;
    logic [SHAMT_W-1:0] shamt;
    logic [5:0]         funct;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_out;
    logic               busy;

    // Pipeline side that issues operations and consumes results.
    modport master (
        output in_valid, src_data, tar_data, shamt, funct, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    // ALU side.
    modport slave (
        input  in_valid, src_data, tar_data, shamt, funct, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/alu_seq_mul_iter.sv
// Iterative unsigned shift-add multiplier retiring MUL_BITS multiplier bits per cycle.
// o_done pulses during the final iteration cycle, with o_product already showing the
// completed product so the caller can capture it at that same edge.
module mul_iter #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);
    localparam int N_ITER = WIDTH / MUL_BITS;
    localparam int CNT_W  = $clog2(N_ITER + 1);

    logic                      r_active;
    logic [CNT_W-1:0]          r_cnt;
    logic [WIDTH-1:0]          r_mcand;
    // Upper half accumulates partial sums; lower half starts as the multiplier and is
    // shifted out MUL_BITS at a time as the product shifts in.
    logic [2*WIDTH-1:0]        r_prod;
    logic [WIDTH+MUL_BITS-1:0] w_partial;
    logic [WIDTH+MUL_BITS-1:0] w_upper;
    logic [2*WIDTH-1:0]        w_next_prod;
    logic                      w_last;

    assign w_partial   = {{MUL_BITS{1'b0}}, r_mcand}
                       * {{WIDTH{1'b0}}, r_prod[MUL_BITS-1:0]};
    assign w_upper     = {{MUL_BITS{1'b0}}, r_prod[2*WIDTH-1:WIDTH]} + w_partial;
    assign w_next_prod = {w_upper, r_prod[WIDTH-1:MUL_BITS]};
    assign w_last      = r_active && (r_cnt == CNT_W'(N_ITER - 1));

    assign o_done    = w_last;
    assign o_product = w_next_prod;

    // Load operands on start, then one shift-add step per cycle until the count expires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_prod   <= {{WIDTH{1'b0}}, i_b};
        end else if (r_active) begin
            r_prod <= w_next_prod;
            if (w_last) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops complete with latency 1; MULTU runs on mul_iter
// and updates HI/LO. Results are held under back-pressure until out_ready.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_data_out;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_product;
    logic [WIDTH-1:0]   w_result;

    assign w_accept = bus.in_valid && bus.in_ready;
    assign w_start  = w_accept && (bus.funct == F_MULTU);

    mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_a       (bus.src_data),
        .i_b       (bus.tar_data),
        .o_done    (w_mul_done),
        .o_product (w_product)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Next state: enter MUL on a MULTU accept, leave when the multiplier finishes.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves the
        // signal unassigned and infers a latch.
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_start)    w_next_state = MUL;
            MUL:  if (w_mul_done) w_next_state = IDLE;
            default:              w_next_state = IDLE;
        endcase
    end

    // FSM outputs: accept only when idle and the output slot is free or draining.
    always_comb begin
        bus.in_ready  = (r_state == IDLE) && (!r_out_valid || bus.out_ready);
        bus.busy      = (r_state == MUL);
        bus.out_valid = r_out_valid;
        bus.data_out  = r_data_out;
    end

    // Single-cycle result selection; unknown codes yield zero.
    always_comb begin
        w_result = '0;
        case (bus.funct)
            F_ADDU: w_result = bus.src_data + bus.tar_data;
            F_SUBU: w_result = bus.src_data - bus.tar_data;
            F_AND:  w_result = bus.src_data & bus.tar_data;
            F_OR:   w_result = bus.src_data | bus.tar_data;
            F_XOR:  w_result = bus.src_data ^ bus.tar_data;
            F_SLL:  w_result = bus.src_data << bus.shamt;
            F_SRL:  w_result = bus.src_data >> bus.shamt;
            F_SRA:  w_result = $unsigned($signed(bus.src_data) >>> bus.shamt);
            F_SLTU: w_result = {{(WIDTH-1){1'b0}}, (bus.src_data < bus.tar_data)};
            F_MFHI: w_result = r_hi;
            F_MFLO: w_result = r_lo;
            default: w_result = '0;
        endcase
    end

    // Result/HI/LO registers: multiply completion, single-cycle accept, or drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: HI/LO are architecturally visible through MFHI/MFLO, so they are
            // reset alongside the control state rather than left undefined.
            r_hi        <= '0;
            r_lo        <= '0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_mul_done) begin
            r_hi        <= w_product[2*WIDTH-1:WIDTH];
            r_lo        <= w_product[WIDTH-1:0];
            r_data_out  <= w_product[WIDTH-1:0];
            r_out_valid <= 1'b1;
        end else if (w_accept && !w_start) begin
            r_data_out  <= w_result;
            r_out_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32/MUL_BITS=1 and WIDTH=16/MUL_BITS=4.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    alu_seq_if #(.WIDTH(32)) if32 ();
    alu_seq_if #(.WIDTH(16)) if16 ();

    alu_seq #(.WIDTH(32), .MUL_BITS(1)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    alu_seq #(.WIDTH(16), .MUL_BITS(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op on the 32-bit DUT; report result, cycles to out_valid, busy cycles.
    task automatic op32(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] res,
                        output int lat, output int busy_cyc);
        @(negedge clk);
        if32.in_valid = 1'b1; if32.funct = f;
        if32.src_data = a; if32.tar_data = b; if32.shamt = sh;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        lat = 0; busy_cyc = 0; res = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (if32.busy && !if32.in_ready) busy_cyc++;
            if (if32.out_valid) begin
                res = if32.data_out;
                break;
            end
        end
    endtask

    task automatic op16(input logic [5:0] f, input logic [15:0] a, input logic [15:0] b,
                        input logic [3:0] sh, output logic [15:0] res,
                        output int lat, output int busy_cyc);
        @(negedge clk);
        if16.in_valid = 1'b1; if16.funct = f;
        if16.src_data = a; if16.tar_data = b; if16.shamt = sh;
        @(posedge clk);
        #1 if16.in_valid = 1'b0;
        lat = 0; busy_cyc = 0; res = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (if16.busy && !if16.in_ready) busy_cyc++;
            if (if16.out_valid) begin
                res = if16.data_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] r; int lat; int bc;
        n_checks++;
        if (if32.in_ready !== 1'b1 || if32.out_valid !== 1'b0 || if32.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
                     if32.in_ready, if32.out_valid, if32.busy);
        end
        n_checks++;
        if (if32.data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 00000000", if32.data_out);
        end
        op32(F_MFHI, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hi: got %h want 00000000", r);
        end
    endtask

    task automatic test_arith();
        logic [31:0] r; int lat; int bc;
        op32(F_ADDU, 32'hFFFF_FFFF, 32'h1, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h0 || lat !== 1) begin
            n_fail++;
            $display("FAIL addu_wrap: got %h lat %0d want 00000000 lat 1", r, lat);
        end
        op32(F_SUBU, 32'h0, 32'h1, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'hFFFF_FFFF || lat !== 1) begin
            n_fail++;
            $display("FAIL subu_wrap: got %h lat %0d want ffffffff lat 1", r, lat);
        end
    endtask

    task automatic test_logic_shift();
        logic [5:0]  f [8]  = '{F_SRA, F_SRL, F_SLL, F_SLTU, F_AND, F_XOR, F_SLTU, F_OR};
        logic [31:0] a [8]  = '{32'h8000_0000, 32'h8000_0000, 32'h1, 32'h1,
                                32'hF0F0_1234, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_00F0};
        logic [31:0] b [8]  = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF,
                                32'h0FF0_00FF, 32'h0F0F_0F0F, 32'h1, 32'h0000_000F};
        logic [4:0]  s [8]  = '{5'd4, 5'd4, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [31:0] e [8]  = '{32'hF800_0000, 32'h0800_0000, 32'h8000_0000, 32'h1,
                                32'h00F0_0034, 32'hF0F0_0F0F, 32'h0, 32'h0000_00FF};
        logic [31:0] r; int lat; int bc;
        for (int i = 0; i < 8; i++) begin
            op32(f[i], a[i], b[i], s[i], r, lat, bc);
            n_checks++;
            if (r !== e[i] || lat !== 1) begin
                n_fail++;
                $display("FAIL op_vec%0d funct=%b: got %h lat %0d want %h lat 1",
                         i, f[i], r, lat, e[i]);
            end
        end
    endtask

    task automatic test_multu();
        logic [31:0] r; int lat; int bc;
        op32(F_MULTU, 32'hFFFF_FFFF, 32'h2, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'hFFFF_FFFE || lat !== 33 || bc !== 32) begin
            n_fail++;
            $display("FAIL multu32: got %h lat %0d busy %0d want fffffffe lat 33 busy 32",
                     r, lat, bc);
        end
        op32(F_MFHI, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h1) begin
            n_fail++;
            $display("FAIL mfhi32: got %h want 00000001", r);
        end
        op32(F_MFLO, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mflo32: got %h want fffffffe", r);
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        @(negedge clk);
        if32.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.funct = F_ADDU;
        if32.src_data = 32'd3; if32.tar_data = 32'd4; if32.shamt = 5'd0;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if32.out_valid !== 1'b1 || if32.data_out !== 32'd7 || if32.in_ready !== 1'b0)
                bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hold: %0d of 5 cycles not holding data 7 with in_ready low", bad);
        end
        // Present OR together with out_ready: accepted while the old result drains.
        if32.in_valid = 1'b1; if32.funct = F_OR;
        if32.src_data = 32'hF0; if32.tar_data = 32'h0F;
        if32.out_ready = 1'b1;
        #1;
        n_checks++;
        if (if32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_ready: in_ready=%b want 1", if32.in_ready);
        end
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (if32.out_valid !== 1'b1 || if32.data_out !== 32'hFF) begin
            n_fail++;
            $display("FAIL no_bubble: valid=%b data=%h want 1 000000ff",
                     if32.out_valid, if32.data_out);
        end
        @(negedge clk);
        n_checks++;
        if (if32.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL valid_drop: out_valid=%b want 0", if32.out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] r; int lat; int bc; int seen;
        // 0x80000001 * 2 = 0x1_00000002 preloads HI=1, LO=2.
        op32(F_MULTU, 32'h8000_0001, 32'h2, 5'd0, r, lat, bc);
        op32(F_MFHI, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h1) begin
            n_fail++;
            $display("FAIL preload_hi: got %h want 00000001", r);
        end
        @(negedge clk);
        if32.in_valid = 1'b1; if32.funct = F_MULTU;
        if32.src_data = 32'd5; if32.tar_data = 32'd7;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if32.out_valid !== 1'b0 || if32.busy !== 1'b0 || if32.data_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b busy=%b data=%h want 0 0 00000000",
                     if32.out_valid, if32.busy, if32.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (if32.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_ready: in_ready=%b want 1", if32.in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if32.out_valid !== 1'b0 || if32.busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL ghost_result: %0d cycles with valid/busy after reset, want 0", seen);
        end
        op32(F_MFHI, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL hi_cleared: got %h want 00000000", r);
        end
        op32(F_MFLO, 32'h0, 32'h0, 5'd0, r, lat, bc);
        n_checks++;
        if (r !== 32'h0) begin
            n_fail++;
            $display("FAIL lo_cleared: got %h want 00000000", r);
        end
    endtask

    task automatic test_unknown();
        logic [31:0] r; int lat; int bc;
        op32(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, r, lat, bc);
        n_checks++;
        if (r !== 32'h0 || lat !== 1) begin
            n_fail++;
            $display("FAIL unknown_funct: got %h lat %0d want 00000000 lat 1", r, lat);
        end
    endtask

    task automatic test_width16();
        logic [15:0] r; int lat; int bc;
        op16(F_ADDU, 16'hFFFF, 16'h1, 4'd0, r, lat, bc);
        n_checks++;
        if (r !== 16'h0 || lat !== 1) begin
            n_fail++;
            $display("FAIL addu16: got %h lat %0d want 0000 lat 1", r, lat);
        end
        op16(F_SRA, 16'h8000, 16'h0, 4'd4, r, lat, bc);
        n_checks++;
        if (r !== 16'hF800) begin
            n_fail++;
            $display("FAIL sra16: got %h want f800", r);
        end
        op16(F_MULTU, 16'hFFFF, 16'h2, 4'd0, r, lat, bc);
        n_checks++;
        if (r !== 16'hFFFE || lat !== 5 || bc !== 4) begin
            n_fail++;
            $display("FAIL multu16: got %h lat %0d busy %0d want fffe lat 5 busy 4", r, lat, bc);
        end
        op16(F_MFHI, 16'h0, 16'h0, 4'd0, r, lat, bc);
        n_checks++;
        if (r !== 16'h1) begin
            n_fail++;
            $display("FAIL mfhi16: got %h want 0001", r);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; if32.funct = '0;
        if32.src_data = '0; if32.tar_data = '0; if32.shamt = '0;
        if16.in_valid = 1'b0; if16.out_ready = 1'b1; if16.funct = '0;
        if16.src_data = '0; if16.tar_data = '0; if16.shamt = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_arith();
        test_logic_shift();
        test_multu();
        test_back_to_back();
        test_reset_mid_mul();
        test_unknown();
        test_width16();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
